// File: rtl/cordic_vectoring_top_if.sv
// Request/result bundle for the vectoring CORDIC: the operand handshake in one
// direction, and the busy/done/angle/magnitude results in the other.
interface cordic_vectoring_top_if;
    logic               clk_en;
    logic               start;
    logic signed [23:0] x_in;
    logic signed [23:0] y_in;
    logic               busy;
    logic               done;
    logic signed [23:0] angle;
    logic        [23:0] mag;
    logic               range_err;

    modport master (
        output clk_en, start, x_in, y_in,
        input  busy, done, angle, mag, range_err
    );

    modport slave (
        input  clk_en, start, x_in, y_in,
        output busy, done, angle, mag, range_err
    );
endinterface

// File: rtl/cordic_vectoring_top.sv
// Vectoring-mode CORDIC: atan2(y, x) in Q3.21 and gain-compensated magnitude in Q2.22.
// Define CORDIC_QUADRANT_EXT_EN for a full-circle pre-rotation; otherwise x < 0 raises range_err.
module cordic_vectoring_top #(
    parameter int FOLD_FACT = 4,
    parameter int CORD_ITER = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cordic_vectoring_top_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        SCALE,
        DONE
    } state_t;

    localparam logic [23:0] K_Q22 = 24'h26DD3B;

    state_t             state_reg;
    logic [4:0]         count_reg;
    logic signed [25:0] x_reg;
    logic signed [25:0] y_reg;
    logic signed [23:0] z_reg;
    logic               zero_reg;
    logic               err_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               range_err_reg;
    logic signed [23:0] angle_reg;
    logic [23:0]        mag_reg;

    // atan(2^-i) in Q3.21, rounded to nearest
    function automatic logic signed [23:0] atan_lut(input logic [4:0] idx);
        logic signed [23:0] val;
        case (idx)
            5'd0:    val = 24'sh1921FB;
            5'd1:    val = 24'sh0ED634;
            5'd2:    val = 24'sh07D6DD;
            5'd3:    val = 24'sh03FAB7;
            5'd4:    val = 24'sh01FF56;
            5'd5:    val = 24'sh00FFEB;
            5'd6:    val = 24'sh007FFD;
            5'd7:    val = 24'sh004000;
            5'd8:    val = 24'sh002000;
            5'd9:    val = 24'sh001000;
            5'd10:   val = 24'sh000800;
            5'd11:   val = 24'sh000400;
            5'd12:   val = 24'sh000200;
            5'd13:   val = 24'sh000100;
            5'd14:   val = 24'sh000080;
            5'd15:   val = 24'sh000040;
            5'd16:   val = 24'sh000020;
            5'd17:   val = 24'sh000010;
            5'd18:   val = 24'sh000008;
            5'd19:   val = 24'sh000004;
            5'd20:   val = 24'sh000002;
            5'd21:   val = 24'sh000001;
            default: val = 24'sh000000;
        endcase
        return val;
    endfunction

    logic signed [25:0] x_ext;
    logic signed [25:0] y_ext;
    logic signed [25:0] x_load;
    logic signed [25:0] y_load;
    logic signed [23:0] z_load;
    logic               load_err;

    assign x_ext = {{2{bus.x_in[23]}}, bus.x_in};
    assign y_ext = {{2{bus.y_in[23]}}, bus.y_in};

`ifdef CORDIC_QUADRANT_EXT_EN
    localparam logic signed [23:0] HALF_PI = 24'sh3243F7;

    // Left half-plane vectors are turned by -+pi/2 so the iterations only see x >= 0
    always_comb begin
        x_load   = x_ext;
        y_load   = y_ext;
        z_load   = '0;
        load_err = 1'b0;
        if (x_ext[25]) begin
            if (!y_ext[25]) begin
                x_load = y_ext;
                y_load = -x_ext;
                z_load = HALF_PI;
            end else begin
                x_load = -y_ext;
                y_load = x_ext;
                z_load = -HALF_PI;
            end
        end
    end
`else
    always_comb begin
        x_load   = x_ext;
        y_load   = y_ext;
        z_load   = '0;
        load_err = bus.x_in[23];
    end
`endif

    logic signed [25:0] x_chain [FOLD_FACT+1];
    logic signed [25:0] y_chain [FOLD_FACT+1];
    logic signed [23:0] z_chain [FOLD_FACT+1];

    assign x_chain[0] = x_reg;
    assign y_chain[0] = y_reg;
    assign z_chain[0] = z_reg;

    // FOLD_FACT micro-rotations chained combinationally, shift = count + stage
    genvar gi;
    generate
        for (gi = 0; gi < FOLD_FACT; gi++) begin : g_stage
            logic [4:0]         shift;
            logic signed [25:0] x_sh;
            logic signed [25:0] y_sh;
            logic signed [23:0] atan_i;
            logic               y_neg;

            assign shift  = count_reg + 5'(gi);
            assign x_sh   = x_chain[gi] >>> shift;
            assign y_sh   = y_chain[gi] >>> shift;
            assign atan_i = atan_lut(shift);
            assign y_neg  = y_chain[gi][25];

            assign x_chain[gi+1] = y_neg ? (x_chain[gi] - y_sh)   : (x_chain[gi] + y_sh);
            assign y_chain[gi+1] = y_neg ? (y_chain[gi] + x_sh)   : (y_chain[gi] - x_sh);
            assign z_chain[gi+1] = y_neg ? (z_chain[gi] - atan_i) : (z_chain[gi] + atan_i);
        end
    endgenerate

    logic signed [49:0] prod;
    logic signed [49:0] prod_q;
    logic [23:0]        mag_sat;

    assign prod   = 50'(x_reg) * 50'($signed({1'b0, K_Q22}));
    assign prod_q = prod >>> 22;

    always_comb begin
        if (prod_q < 0) begin
            mag_sat = '0;
        end else if (prod_q > 50'sd8388607) begin
            mag_sat = 24'h7FFFFF;
        end else begin
            mag_sat = prod_q[23:0];
        end
    end

    logic iter_last;
    assign iter_last = (count_reg + 5'(FOLD_FACT)) == 5'(CORD_ITER);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            z_reg         <= '0;
            zero_reg      <= 1'b0;
            err_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            range_err_reg <= 1'b0;
            angle_reg     <= '0;
            mag_reg       <= '0;
        end else if (bus.clk_en) begin
            done_reg <= 1'b0;
            // A new start always wins; a finishing DONE still reports its result
            if (bus.start) begin
                if (state_reg == DONE) begin
                    done_reg <= 1'b1;
                end
                x_reg     <= x_load;
                y_reg     <= y_load;
                z_reg     <= z_load;
                zero_reg  <= (bus.x_in == 24'sd0) && (bus.y_in == 24'sd0);
                err_reg   <= load_err;
                count_reg <= '0;
                busy_reg  <= 1'b1;
                state_reg <= ITER;
            end else begin
                case (state_reg)
                    IDLE: begin
                        busy_reg <= 1'b0;
                    end
                    ITER: begin
                        x_reg     <= x_chain[FOLD_FACT];
                        y_reg     <= y_chain[FOLD_FACT];
                        z_reg     <= z_chain[FOLD_FACT];
                        count_reg <= count_reg + 5'(FOLD_FACT);
                        if (iter_last) begin
                            state_reg <= SCALE;
                        end
                    end
                    SCALE: begin
                        angle_reg     <= (err_reg || zero_reg) ? 24'sd0 : z_reg;
                        mag_reg       <= err_reg ? 24'd0 : mag_sat;
                        range_err_reg <= err_reg;
                        state_reg     <= DONE;
                    end
                    DONE: begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.angle     = angle_reg;
    assign bus.mag       = mag_reg;
    assign bus.range_err = range_err_reg;

endmodule

// File: tb/tb_cordic_vectoring_top.sv
// Directed scoreboard bench for cordic_vectoring_top: expected results are queued at
// start and checked against each done pulse, including latency in clock cycles.
module tb_cordic_vectoring_top;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    cordic_vectoring_top_if bus();

    cordic_vectoring_top #(
        .FOLD_FACT(4),
        .CORD_ITER(16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [23:0] angle;
        int          atol;
        logic [23:0] mag;
        int          mtol;
        logic        err;
        int          lat;
        time         t0;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert   = 0;
    int   n_fail     = 0;
    int   done_count = 0;
    int   c0;

    always @(posedge clk) begin
        if (bus.done === 1'b1) done_count++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_tol(input string tag, input logic [23:0] got, input logic [23:0] exp,
                             input int tol);
        int diff;
        diff = int'($signed(got)) - int'($signed(exp));
        if (diff < 0) diff = -diff;
        n_assert++;
        assert (diff <= tol) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h +/- %0d", tag, got, exp, tol);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge
    task automatic drive_start(input logic [23:0] x, input logic [23:0] y);
        bus.start = 1'b1;
        bus.x_in  = x;
        bus.y_in  = y;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic start_op(input logic [23:0] x, input logic [23:0] y, input string tag,
                            input logic [23:0] angle, input int atol,
                            input logic [23:0] mag, input int mtol,
                            input logic err, input int lat);
        exp_t e;
        drive_start(x, y);
        e.tag = tag; e.angle = angle; e.atol = atol; e.mag = mag; e.mtol = mtol;
        e.err = err; e.lat = lat; e.t0 = $time;
        sb_q.push_back(e);
        $display("start %s x=%h y=%h", tag, x, y);
    endtask

    task automatic wait_done(input string tag, input int budget);
        exp_t e;
        int   i;
        bit   seen;
        i    = 0;
        seen = 1'b0;
        while (!seen && i <= budget) begin
            if (bus.done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                i++;
            end
        end
        n_assert++;
        assert (seen === 1'b1) else begin
            n_fail++;
            $error("FAIL %s_timeout: done not seen within %0d cycles", tag, budget);
        end
        if (!seen) return;
        check_eq({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check_eq({e.tag, "_latency"}, 32'(($time - e.t0) / 10), 32'(e.lat));
        check_tol({e.tag, "_angle"}, bus.angle, e.angle, e.atol);
        check_tol({e.tag, "_mag"}, bus.mag, e.mag, e.mtol);
        check_eq({e.tag, "_range_err"}, 32'(bus.range_err), 32'(e.err));
        $display("done %s angle=%h mag=%h range_err=%b", e.tag, bus.angle, bus.mag, bus.range_err);
        @(negedge clk);
        check_eq({e.tag, "_done_width"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.clk_en = 1'b1;
        bus.start  = 1'b0;
        bus.x_in   = '0;
        bus.y_in   = '0;
        reset_n    = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy",      32'(bus.busy),      32'd0);
        check_eq("rst_done",      32'(bus.done),      32'd0);
        check_eq("rst_angle",     32'(bus.angle),     32'd0);
        check_eq("rst_mag",       32'(bus.mag),       32'd0);
        check_eq("rst_range_err", 32'(bus.range_err), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        start_op(24'h400000, 24'h000000, "unit_x", 24'h000000, 128, 24'h400000, 16, 1'b0, 6);
        wait_done("unit_x", 20);
        start_op(24'h2D413D, 24'h2D413D, "diag45", 24'h1921FB, 128, 24'h400000, 16, 1'b0, 6);
        wait_done("diag45", 20);
        start_op(24'h000000, 24'hE00000, "neg_y", 24'hCDBC09, 128, 24'h200000, 16, 1'b0, 6);
        wait_done("neg_y", 20);
`ifdef CORDIC_QUADRANT_EXT_EN
        start_op(24'hE00000, 24'h200000, "q2", 24'h4B65F2, 128, 24'h2D413D, 16, 1'b0, 6);
`else
        start_op(24'hE00000, 24'h200000, "q2_err", 24'h000000, 0, 24'h000000, 0, 1'b1, 6);
`endif
        wait_done("q2", 20);
        start_op(24'h000000, 24'h000000, "zero", 24'h000000, 0, 24'h000000, 0, 1'b0, 6);
        wait_done("zero", 20);

        // clk_en low for three edges mid-ITER
        start_op(24'h400000, 24'h000000, "stall", 24'h000000, 128, 24'h400000, 16, 1'b0, 9);
        @(negedge clk);
        bus.clk_en = 1'b0;
        repeat (3) @(negedge clk);
        bus.clk_en = 1'b1;
        wait_done("stall", 20);

        // operand A aborted by operand B two cycles later
        c0 = done_count;
        drive_start(24'h400000, 24'h000000);
        @(negedge clk);
        start_op(24'h2D413D, 24'h2D413D, "abort_b", 24'h1921FB, 128, 24'h400000, 16, 1'b0, 6);
        wait_done("abort_b", 20);
        @(negedge clk);
        check_eq("abort_done_pulses", 32'(done_count - c0), 32'd1);

        // back-to-back: new start on the DONE edge
        start_op(24'h400000, 24'h000000, "b2b_a", 24'h000000, 128, 24'h400000, 16, 1'b0, 6);
        repeat (5) @(negedge clk);
        start_op(24'h000000, 24'hE00000, "b2b_b", 24'hCDBC09, 128, 24'h200000, 16, 1'b0, 6);
        wait_done("b2b_a", 20);
        wait_done("b2b_b", 20);

        // asynchronous reset mid-ITER
        c0 = done_count;
        drive_start(24'h2D413D, 24'h2D413D);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_busy",  32'(bus.busy),  32'd0);
        check_eq("arst_done",  32'(bus.done),  32'd0);
        check_eq("arst_angle", 32'(bus.angle), 32'd0);
        check_eq("arst_mag",   32'(bus.mag),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("arst_no_done", 32'(done_count - c0), 32'd0);
        start_op(24'h2D413D, 24'h2D413D, "after_rst", 24'h1921FB, 128, 24'h400000, 16, 1'b0, 6);
        wait_done("after_rst", 20);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_vectoring_top.md
Name: cordic_vectoring_top

Overview:
- Vectoring-mode CORDIC: the inverse of the rotation-mode cosine unit.
- Takes a fixed-point vector (x, y). Returns its angle atan2(y, x) and its gain-compensated magnitude sqrt(x²+y²).
- Uses the same start/done, clk_en-gated, folded-iteration architecture as the rotation core.
- Sits beside the rotation core in the CORDIC IP and feeds the float converters downstream.

Parameters:
- FOLD_FACT, 4: CORDIC micro-rotations chained combinationally per clock. Must divide CORD_ITER.
- CORD_ITER, 16: total micro-rotations. Range 8..22.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clk_en  in  1  clock enable. Low freezes all state.
- start  in  1  sample x_in/y_in and begin an operation.
- x_in  in  24  signed Q2.22 x component, |x| < 1.0.
- y_in  in  24  signed Q2.22 y component, |y| < 1.0.
- busy  out  1  operation in progress.
- done  out  1  one-cycle result-valid pulse. Qualified by clk_en.
- angle  out  24  signed Q3.21 radians.
- mag  out  24  unsigned-valued Q2.22 magnitude, gain removed.
- range_err  out  1  input outside the supported domain. Valid with done.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State = IDLE.
  - busy, done, range_err = 0.
  - angle, mag = 0.
  - Iteration counter = 0.
- Internal datapath:
  - x and y are 26-bit signed (Q4.22), so the CORDIC gain (~1.647) cannot overflow.
  - z is 24-bit Q3.21.
  - Arctangent table atan(2^-i), i = 0..21, is stored in Q3.21 and rounded to nearest.
- Micro-rotation i:
  - If y >= 0: x' = x + (y >>> i); y' = y - (x >>> i); z' = z + atan_i.
  - Else: x' = x - (y >>> i); y' = y + (x >>> i); z' = z - atan_i.
  - Shifts are arithmetic.
- State machine. Only advances when clk_en = 1; when clk_en = 0 every register, including done, holds.
  - IDLE, start = 1:
    - Load x, y, z from inputs (z = 0, or the pre-rotation value).
    - count = 0, busy = 1, go to ITER.
  - ITER:
    - Apply FOLD_FACT micro-rotations, shifts count .. count+FOLD_FACT-1.
    - count += FOLD_FACT.
    - When count reaches CORD_ITER, go to SCALE.
  - SCALE:
    - mag = (x * 24'h26DD3B) >> 22, i.e. multiply by K = 0.607253 in Q2.22, truncated, saturated to 24'h7FFFFF.
    - angle = z.
    - Go to DONE.
  - DONE:
    - done = 1 for exactly one enabled cycle; busy = 0.
    - Go to IDLE.
- Latency: done is high in the enabled cycle that is CORD_ITER/FOLD_FACT + 2 enabled edges after the start edge (6 at defaults).
- angle, mag and range_err hold until the next SCALE.
- start while busy: abort the current operation and reload from the new inputs. No done is issued for the aborted operation.
- start in DONE: done still pulses for the finished operation, and the new operation loads on the same edge.
- x = y = 0: angle = 0, mag = 0, range_err = 0.
- reset_n asserted mid-operation clears everything immediately. No done is issued.

Optional Feature:
- Macro: CORDIC_QUADRANT_EXT_EN.
- Defined: full-circle pre-rotation at load, so angle covers (-pi, pi]; range_err is tied to 0.
  - x < 0 and y >= 0: (x, y) = (y, -x), z0 = +pi/2 (24'h3243F7).
  - x < 0 and y < 0: (x, y) = (-y, x), z0 = -pi/2.
- Undefined: no pre-rotation; valid angle domain is [-pi/2, pi/2].
  - An input with x < 0 sets range_err = 1 with the done pulse and forces angle = mag = 0.
  - Iteration timing is unchanged.

Test Plan:
- x=24'h400000, y=0, start: done exactly 6 cycles later; angle=0 ±128 LSB; mag=24'h400000 ±16 LSB; range_err=0.
- x=y=24'h2D413D (0.7071): angle=24'h1921FB (pi/4) ±128; mag=24'h400000 ±16. Then x=0, y=24'hE00000 gives angle=-pi/2 (24'hCDBC09) ±128, mag=24'h200000.
- x=24'hE00000, y=24'h200000: with CORDIC_QUADRANT_EXT_EN, angle=24'h4B65F2 (3pi/4) ±128, mag=24'h2D413D ±16. Without it, range_err=1, angle=mag=0.
- Operand 1 started, clk_en held low 3 cycles mid-ITER: done arrives exactly 3 cycles late; results identical to the unstalled run; done never lost.
- start with operand A, then start with operand B 2 cycles later: exactly one done pulse, carrying B's results, 6 cycles after the B start.
- reset_n pulsed low mid-ITER: busy/done/angle/mag drop to 0 asynchronously with no done. The next start completes normally.
